// File: rtl/serial_subtractor_pkg.sv
// sub_pkg: shared types and helpers for the serial subtractor.
//   state_e   - FSM states (IDLE / RUN / DONE)
//   cnt_width - digit-counter width, clog2(ndig) but never below 1 bit
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-digit operation still needs a 1-bit counter so the
    // counter declaration never collapses to zero width.
    function automatic int cnt_width(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/serial_subtractor_slice.sv
// full_subtractor_slice: combinational DIGIT-bit ripple-borrow subtractor.
// Ports:
//   a, b  [DIGIT-1:0] - minuend / subtrahend slice
//   bin               - borrow into the least significant bit
//   diff  [DIGIT-1:0] - a - b - bin (modulo 2^DIGIT)
//   bout              - borrow out of the most significant bit
module full_subtractor_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);

    logic [DIGIT:0] br;

    // Chain of 1-bit full subtractors: a borrow is produced when b exceeds a,
    // or when the bits are equal and a borrow is already pending.
    always_comb begin
        br    = '0;
        diff  = '0;
        br[0] = bin;
        for (int i = 0; i < DIGIT; i++) begin
            diff[i]  = a[i] ^ b[i] ^ br[i];
            br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
        bout = br[DIGIT];
    end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle unsigned subtractor, D = X - Y - Bin over
// WIDTH bits, DIGIT bits per clock with the borrow carried between cycles.
// Ports:
//   clk, rst_n           - rising-edge clock, async active-low reset
//   in_valid / in_ready  - operand handshake (x, y, bin, sat captured together)
//   out_valid / out_ready- result handshake (d, bout)
//   d, bout              - difference and final borrow (zero when not valid)
//   busy                 - high while an operation is in RUN or DONE
//   fsm_state            - current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holding valid keeps its data stable until that edge.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_params
        $fatal(1, "serial_subtractor: WIDTH must be a positive multiple of DIGIT");
    end

    state_e           state;
    state_e           state_nx;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic             sat_q;
    logic             alive_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] sl_x;
    logic [DIGIT-1:0] sl_y;
    logic [DIGIT-1:0] sl_d;
    logic             sl_b;
    logic             accept;
    logic             last;

    assign accept = in_valid & in_ready;
    assign last   = (cnt_q == CNT_LAST);

    assign sl_x = x_q[DIGIT*int'(cnt_q) +: DIGIT];
    assign sl_y = y_q[DIGIT*int'(cnt_q) +: DIGIT];

    full_subtractor_slice #(.DIGIT(DIGIT)) u_slice (
        .a    (sl_x),
        .b    (sl_y),
        .bin  (borrow_q),
        .diff (sl_d),
        .bout (sl_b)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Output logic. alive_q keeps in_ready low until the first edge after
    // reset release, since state is already IDLE while reset is held.
    always_comb begin
        in_ready  = alive_q && (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    // Operand, result, borrow and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            sat_q    <= 1'b0;
            cnt_q    <= '0;
            alive_q  <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (accept) begin
                x_q      <= x;
                y_q      <= y;
                sat_q    <= sat;
                borrow_q <= bin;
                cnt_q    <= '0;
                res_q    <= '0;
            end else if (state == RUN) begin
                res_q[DIGIT*int'(cnt_q) +: DIGIT] <= sl_d;
                borrow_q <= sl_b;
                // The terminal count moves the FSM to DONE, so the counter
                // simply stops there rather than wrapping.
                if (!last) cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Outputs are forced to zero outside DONE so a partial result never shows.
    assign d         = (out_valid && !(sat_q && borrow_q)) ? res_q : '0;
    assign bout      = out_valid & borrow_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  // main instance: WIDTH=16, DIGIT=4
  logic        rst_n, in_valid, in_ready, bin, sat, out_valid, out_ready, bout, busy;
  logic [15:0] x, y, d;
  logic [1:0]  fsm_state;

  // small instances: WIDTH=3 with DIGIT=1 and DIGIT=3, shared stimulus
  logic       rst3_n, iv3, b3, s3, or3;
  logic [2:0] x3, y3;
  logic       rdy1, ov1, bo1, busy1, rdy3, ov3, bo3, busy3;
  logic [2:0] d1, d3;
  logic [1:0] st1, st3;

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .bin(bin), .sat(sat), .out_valid(out_valid),
    .out_ready(out_ready), .d(d), .bout(bout), .busy(busy), .fsm_state(fsm_state)
  );

  serial_subtractor #(.WIDTH(3), .DIGIT(1)) u_w3d1 (
    .clk(clk), .rst_n(rst3_n), .in_valid(iv3), .in_ready(rdy1),
    .x(x3), .y(y3), .bin(b3), .sat(s3), .out_valid(ov1),
    .out_ready(or3), .d(d1), .bout(bo1), .busy(busy1), .fsm_state(st1)
  );

  serial_subtractor #(.WIDTH(3), .DIGIT(3)) u_w3d3 (
    .clk(clk), .rst_n(rst3_n), .in_valid(iv3), .in_ready(rdy3),
    .x(x3), .y(y3), .bin(b3), .sat(s3), .out_valid(ov3),
    .out_ready(or3), .d(d3), .bout(bo3), .busy(busy3), .fsm_state(st3)
  );

  // ---------------- reference model ----------------
  // Integer arithmetic: borrow when X < Y + Bin, result modulo 2^w,
  // clamped to zero under saturation with a borrow.
  function automatic void ref_sub(input int w, input longint xv, input longint yv,
                                  input bit bv, input bit sv,
                                  output longint dv, output bit bo);
    longint t;
    t  = xv - yv - longint'(bv);
    bo = (xv < yv + longint'(bv));
    if (t < 0) t = t + (longint'(1) << w);
    dv = t;
    if (sv && bo) dv = 0;
  endfunction

  // ---------------- driver / check tasks ----------------
  // One full operation on the main instance: accept, latency, result,
  // 'hold' cycles of backpressure, release. With poke=1 a new operand is
  // offered during the hold and through the release edge.
  task automatic run_op(input logic [15:0] xv, input logic [15:0] yv, input logic bv,
                        input logic sv, input int hold, input bit poke, input string tag);
    longint dv;
    bit bo;
    int lat;
    logic [16:0] e;
    logic [15:0] d_seen;
    logic        b_seen;
    ref_sub(16, longint'(xv), longint'(yv), bv, sv, dv, bo);
    exp_q.push_back({bo, dv[15:0]});
    for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1; x = xv; y = yv; bin = bv; sat = sv;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; x = 16'($urandom); y = 16'($urandom); bin = 1'($urandom); sat = 1'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_accept: got %b want 1", tag, busy);
    end
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) begin lat = i; break; end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL %s latency: got %0d want 4", tag, lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (d !== e[15:0] || bout !== e[16]) begin
      errors++; $display("FAIL %s result: got d=%h bout=%b want d=%h bout=%b", tag, d, bout, e[15:0], e[16]);
    end
    d_seen = d; b_seen = bout;
    if (poke) begin in_valid = 1'b1; x = 16'($urandom); y = 16'($urandom); end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || d !== d_seen || bout !== b_seen || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: got ov=%b d=%h bout=%b rdy=%b want ov=1 d=%h bout=%b rdy=0",
                 tag, i, out_valid, d, bout, in_ready, d_seen, b_seen);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: got ov=%b rdy=%b busy=%b want ov=0 rdy=1 busy=0", tag, out_valid, in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || d !== 16'h0 || bout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b ov=%b d=%h bout=%b busy=%b want all 0", in_ready, out_valid, d, bout, busy);
    end
    @(negedge clk); rst_n = 1'b1; rst3_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ready_after_reset: got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h0235, 1'b0, 1'b0, 0, 1'b0, "basic");
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0, 1, 1'b0, "underflow");
    run_op(16'h0000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, "saturate");
    run_op(16'h8000, 16'h7FFF, 1'b1, 1'b0, 0, 1'b0, "bin_exact");
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1'b0, "bin_wrap");
  endtask

  task automatic test_backpressure();
    run_op(16'hBEEF, 16'hCAFE, 1'b0, 1'b0, 5, 1'b1, "backpressure");
  endtask

  task automatic test_abort();
    int seen;
    in_valid = 1'b1; x = 16'h5555; y = 16'h1111; bin = 1'b0; sat = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || d !== 16'h0 || bout !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got ov=%b d=%h bout=%b busy=%b rdy=%b want all 0", out_valid, d, bout, busy, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen);
    end
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), 1'($urandom), "random");
  endtask

  task automatic test_exhaustive_w3();
    longint dv;
    bit bo;
    int lat1, lat3;
    logic [2:0] dd1, dd3;
    logic bb1, bb3;
    logic [2:0] xv, yv;
    logic s;
    or3 = 1'b1;
    for (int i = 0; i < 128; i++) begin
      xv = 3'(i >> 4); yv = 3'(i >> 1); s = 1'($urandom);
      ref_sub(3, longint'(xv), longint'(yv), i[0], s, dv, bo);
      iv3 = 1'b1; x3 = xv; y3 = yv; b3 = i[0]; s3 = s;
      @(posedge clk); @(negedge clk);
      iv3 = 1'b0; x3 = 3'($urandom); y3 = 3'($urandom);
      lat1 = -1; lat3 = -1; dd1 = 'x; dd3 = 'x; bb1 = 1'bx; bb3 = 1'bx;
      for (int k = 0; k < 7; k++) begin
        if (ov1 === 1'b1 && lat1 < 0) begin lat1 = k; dd1 = d1; bb1 = bo1; end
        if (ov3 === 1'b1 && lat3 < 0) begin lat3 = k; dd3 = d3; bb3 = bo3; end
        @(posedge clk); @(negedge clk);
      end
      checks++;
      if (lat1 != 3 || dd1 !== dv[2:0] || bb1 !== bo) begin
        errors++;
        $display("FAIL w3d1 x=%0d y=%0d b=%0d s=%0d: got lat=%0d d=%0d bout=%b want lat=3 d=%0d bout=%b",
                 xv, yv, i[0], s, lat1, dd1, bb1, dv[2:0], bo);
      end
      checks++;
      if (lat3 != 1 || dd3 !== dv[2:0] || bb3 !== bo) begin
        errors++;
        $display("FAIL w3d3 x=%0d y=%0d b=%0d s=%0d: got lat=%0d d=%0d bout=%b want lat=1 d=%0d bout=%b",
                 xv, yv, i[0], s, lat3, dd3, bb3, dv[2:0], bo);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; bin = 1'b0; sat = 1'b0;
    iv3 = 1'b0; or3 = 1'b0; x3 = '0; y3 = '0; b3 = 1'b0; s3 = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_random();
    test_exhaustive_w3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
